// File: rtl/issue_select_pkg.sv
// ---------------------------------------------------------------------------
// issue_select_pkg
// Shared core definitions used by dispatch, the issue queue, register read
// and execute: default sizing constants and the renamed-uop record.
//   CORE_PREG_W      physical register tag width
//   CORE_IQ_DEPTH    issue queue entries (power of two, >= 4)
//   CORE_NUM_WAKEUP  execute broadcast / bypass port count
//   uop_t            renamed uop: source/destination tags, source-ready
//                    flags at rename time, opaque payload
// ---------------------------------------------------------------------------
package issue_select_pkg;

    localparam int CORE_PREG_W     = 6;
    localparam int CORE_IQ_DEPTH   = 16;
    localparam int CORE_NUM_WAKEUP = 4;
    localparam int PAYLOAD_W       = 16;

    typedef struct packed {
        logic [CORE_PREG_W-1:0] src1_reg;
        logic [CORE_PREG_W-1:0] src2_reg;
        logic [CORE_PREG_W-1:0] dst_reg;
        logic                   src1_rdy;
        logic                   src2_rdy;
        logic [PAYLOAD_W-1:0]   payload;
    } uop_t;

endpackage

// File: rtl/issue_select_picker.sv
// ---------------------------------------------------------------------------
// iq_picker
// Picks one requester out of N. With AGE_EN=0 the lowest index wins; with
// AGE_EN=1 the requester that no other requester is older than wins.
// Ports:
//   req_i    request vector
//   age_i    age matrix, age_i[r][c]=1 means entry r is older than entry c
//            (ignored when AGE_EN=0)
//   grant_o  one-hot grant (all zero when no request)
//   idx_o    binary index of the granted requester
//   any_o    at least one request present
// ---------------------------------------------------------------------------
module iq_picker #(
    parameter int N      = 16,
    parameter bit AGE_EN = 1'b0
) (
    input  logic [N-1:0]         req_i,
    input  logic [N-1:0][N-1:0]  age_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    genvar gi, gj;

    generate
        if (AGE_EN) begin : g_age
            for (gi = 0; gi < N; gi++) begin : g_row
                // Requesters that are older than entry gi block it.
                logic [N-1:0] older;
                for (gj = 0; gj < N; gj++) begin : g_col
                    assign older[gj] = req_i[gj] & age_i[gj][gi];
                end
                assign grant_o[gi] = req_i[gi] & ~|older;
            end
        end else begin : g_fixed
            logic unused_age;
            assign unused_age = ^age_i;
            for (gi = 0; gi < N; gi++) begin : g_bit
                if (gi == 0) begin : g_first
                    assign grant_o[gi] = req_i[gi];
                end else begin : g_rest
                    assign grant_o[gi] = req_i[gi] & ~|req_i[gi-1:0];
                end
            end
        end
    endgenerate

    // Grant is one-hot, so OR-ing the indices of set bits encodes it.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_o[i]) begin
                idx_o = idx_o | i[$clog2(N)-1:0];
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/issue_select.sv
// ---------------------------------------------------------------------------
// issue_select
// Unified issue queue: accepts renamed uops, tracks operand readiness from
// execute tag broadcasts and issues one ready uop per cycle to register read.
// Build option: define IQ_AGE_SELECT_EN for oldest-first select through an
// age matrix; otherwise the lowest-index ready entry is issued.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   dispatch_*      uop handshake from dispatch (ready depends on count only)
//   wakeup_valid/tag  result-tag broadcasts from execute
//   flush           squash queued and selected uops
//   sel_stall       register read cannot take a new uop
//   sel_valid/uop   registered issue outputs
// ---------------------------------------------------------------------------
module issue_select
    import issue_select_pkg::*;
#(
    parameter int IQ_DEPTH   = CORE_IQ_DEPTH,
    parameter int PREG_W     = CORE_PREG_W,
    parameter int NUM_WAKEUP = CORE_NUM_WAKEUP
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                dispatch_valid,
    output logic                                dispatch_ready,
    input  uop_t                                dispatch_uop,
    input  logic [NUM_WAKEUP-1:0]               wakeup_valid,
    input  logic [NUM_WAKEUP-1:0][PREG_W-1:0]   wakeup_tag,
    input  logic                                flush,
    input  logic                                sel_stall,
    output logic                                sel_valid,
    output uop_t                                sel_uop
);

    localparam int IDX_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IQ_DEPTH);

    function automatic logic tag_hit(
        input logic [PREG_W-1:0]                  tag,
        input logic [NUM_WAKEUP-1:0]              vld,
        input logic [NUM_WAKEUP-1:0][PREG_W-1:0]  tags
    );
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < NUM_WAKEUP; p++) begin
            hit = hit | (vld[p] && (tags[p] == tag));
        end
        return hit;
    endfunction

    logic [IQ_DEPTH-1:0] entry_valid, entry_rdy1, entry_rdy2, eligible;
    uop_t                entry_uop [IQ_DEPTH];
    logic [IQ_DEPTH-1:0] sel_grant, free_grant;
    logic [IDX_W-1:0]    sel_idx, unused_free_idx;
    logic                sel_any, free_any, sel_fire, accept;
    logic                disp_hit1, disp_hit2;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                sel_valid_q;
    uop_t                sel_uop_q;

    assign eligible       = entry_valid & entry_rdy1 & entry_rdy2;
    assign dispatch_ready = (count_q != FULL_CNT);
    assign accept         = dispatch_valid & dispatch_ready & free_any & ~flush;
    assign sel_fire       = ~sel_stall & sel_any;
    assign disp_hit1      = tag_hit(dispatch_uop.src1_reg, wakeup_valid, wakeup_tag);
    assign disp_hit2      = tag_hit(dispatch_uop.src2_reg, wakeup_valid, wakeup_tag);

    // Free slots come from registered valid bits, so a slot freed by select
    // this cycle is not reused until the next one.
    iq_picker #(.N(IQ_DEPTH), .AGE_EN(1'b0)) u_free_pick (
        .req_i   (~entry_valid),
        .age_i   ('0),
        .grant_o (free_grant),
        .idx_o   (unused_free_idx),
        .any_o   (free_any)
    );

`ifdef IQ_AGE_SELECT_EN
    logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] age_q;

    iq_picker #(.N(IQ_DEPTH), .AGE_EN(1'b1)) u_sel_pick (
        .req_i   (eligible),
        .age_i   (age_q),
        .grant_o (sel_grant),
        .idx_o   (sel_idx),
        .any_o   (sel_any)
    );
`else
    iq_picker #(.N(IQ_DEPTH), .AGE_EN(1'b0)) u_sel_pick (
        .req_i   (eligible),
        .age_i   ('0),
        .grant_o (sel_grant),
        .idx_o   (sel_idx),
        .any_o   (sel_any)
    );
`endif

    genvar gi;
    generate
        for (gi = 0; gi < IQ_DEPTH; gi++) begin : g_entry
            logic valid_q, rdy1_q, rdy2_q;
            uop_t uop_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    rdy1_q  <= 1'b0;
                    rdy2_q  <= 1'b0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else if (accept && free_grant[gi]) begin
                    // A broadcast in the dispatch cycle must not be lost.
                    valid_q <= 1'b1;
                    rdy1_q  <= dispatch_uop.src1_rdy | disp_hit1;
                    rdy2_q  <= dispatch_uop.src2_rdy | disp_hit2;
                end else begin
                    if (sel_fire && sel_grant[gi]) begin
                        valid_q <= 1'b0;
                    end
                    // Setting ready on an idle slot is harmless: dispatch
                    // overwrites it.
                    if (tag_hit(uop_q.src1_reg, wakeup_valid, wakeup_tag)) begin
                        rdy1_q <= 1'b1;
                    end
                    if (tag_hit(uop_q.src2_reg, wakeup_valid, wakeup_tag)) begin
                        rdy2_q <= 1'b1;
                    end
                end
            end

            // Payload storage needs no reset; the valid bit qualifies it.
            always_ff @(posedge clk) begin
                if (accept && free_grant[gi]) begin
                    uop_q <= dispatch_uop;
                end
            end

`ifdef IQ_AGE_SELECT_EN
            // New entry is younger than every entry currently valid.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    age_q[gi] <= '0;
                end else if (flush) begin
                    age_q[gi] <= '0;
                end else if (accept) begin
                    if (free_grant[gi]) begin
                        age_q[gi] <= '0;
                    end else if (entry_valid[gi]) begin
                        age_q[gi] <= age_q[gi] | free_grant;
                    end
                end
            end
`endif

            assign entry_valid[gi] = valid_q;
            assign entry_rdy1[gi]  = rdy1_q;
            assign entry_rdy2[gi]  = rdy2_q;
            assign entry_uop[gi]   = uop_q;
        end
    endgenerate

    assign count_d = count_q + {{IDX_W{1'b0}}, accept} - {{IDX_W{1'b0}}, sel_fire};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            sel_valid_q <= 1'b0;
            sel_uop_q   <= '0;
        end else if (flush) begin
            count_q     <= '0;
            sel_valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (!sel_stall) begin
                sel_valid_q <= sel_any;
                if (sel_any) begin
                    sel_uop_q <= entry_uop[sel_idx];
                end
            end
        end
    end

    assign sel_valid = sel_valid_q;
    assign sel_uop   = sel_uop_q;

endmodule

// File: tb/tb_issue_select.sv
// ---------------------------------------------------------------------------
// tb_issue_select
// Directed scenarios with literal expectations followed by randomized
// traffic. A behavioural model of the queue (slot array plus dispatch
// sequence numbers for age order) is compared against the DUT every cycle.
// Honours IQ_AGE_SELECT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_issue_select;
    import issue_select_pkg::*;

    localparam int D = 16;
    localparam int W = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                dispatch_valid = 1'b0;
    logic                dispatch_ready;
    uop_t                dispatch_uop = '0;
    logic [W-1:0]        wakeup_valid = '0;
    logic [W-1:0][5:0]   wakeup_tag = '0;
    logic                flush = 1'b0;
    logic                sel_stall = 1'b0;
    logic                sel_valid;
    uop_t                sel_uop;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    issue_select dut (
        .clk            (clk),
        .rst            (rst),
        .dispatch_valid (dispatch_valid),
        .dispatch_ready (dispatch_ready),
        .dispatch_uop   (dispatch_uop),
        .wakeup_valid   (wakeup_valid),
        .wakeup_tag     (wakeup_tag),
        .flush          (flush),
        .sel_stall      (sel_stall),
        .sel_valid      (sel_valid),
        .sel_uop        (sel_uop)
    );

    // ---------------- behavioural model ----------------
    bit   m_valid [D];
    bit   m_r1 [D];
    bit   m_r2 [D];
    uop_t m_uop [D];
    int   m_seq [D];
    int   seq_ctr;
    bit   m_sel_valid;
    uop_t m_sel_uop;
    bit   m_issued;

    function automatic bit woke(input logic [5:0] t);
        for (int p = 0; p < W; p++) begin
            if (wakeup_valid[p] && wakeup_tag[p] == t) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
        m_sel_valid = 1'b0;
        m_sel_uop   = '0;
        m_issued    = 1'b0;
        seq_ctr     = 0;
    endtask

    task automatic model_step();
        int occ, win, slot;
        bit acc;
        m_issued = 1'b0;
        if (flush) begin
            for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
            m_sel_valid = 1'b0;
            return;
        end
        occ = 0;
        for (int i = 0; i < D; i++) occ += int'(m_valid[i]);
        acc = dispatch_valid && (occ != D);
        win = -1;
        for (int i = 0; i < D; i++) begin
            if (m_valid[i] && m_r1[i] && m_r2[i]) begin
`ifdef IQ_AGE_SELECT_EN
                if (win < 0 || m_seq[i] < m_seq[win]) win = i;
`else
                if (win < 0) win = i;
`endif
            end
        end
        slot = -1;
        for (int i = 0; i < D; i++) begin
            if (!m_valid[i] && slot < 0) slot = i;
        end
        for (int i = 0; i < D; i++) begin
            if (m_valid[i]) begin
                if (woke(m_uop[i].src1_reg)) m_r1[i] = 1'b1;
                if (woke(m_uop[i].src2_reg)) m_r2[i] = 1'b1;
            end
        end
        if (!sel_stall) begin
            m_sel_valid = (win >= 0);
            if (win >= 0) begin
                m_sel_uop    = m_uop[win];
                m_valid[win] = 1'b0;
                m_issued     = 1'b1;
            end
        end
        if (acc) begin
            m_valid[slot] = 1'b1;
            m_uop[slot]   = dispatch_uop;
            m_r1[slot]    = dispatch_uop.src1_rdy | woke(dispatch_uop.src1_reg);
            m_r2[slot]    = dispatch_uop.src2_rdy | woke(dispatch_uop.src2_reg);
            m_seq[slot]   = seq_ctr;
            seq_ctr++;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        int occ;
        occ = 0;
        for (int i = 0; i < D; i++) occ += int'(m_valid[i]);
        chk("model_dispatch_ready", 64'(dispatch_ready), 64'(occ != D));
        chk("model_sel_valid", 64'(sel_valid), 64'(m_sel_valid));
        chk("model_sel_uop", 64'(sel_uop), 64'(m_sel_uop));
        if (m_issued && !rst) begin
            $display("[TB] issue payload=%h src1=%0d src2=%0d t=%0t",
                     m_sel_uop.payload, m_sel_uop.src1_reg, m_sel_uop.src2_reg, $time);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic uop_t mk(input logic [5:0] s1, input bit r1,
                                input logic [5:0] s2, input bit r2,
                                input logic [15:0] pl);
        uop_t u;
        u          = '0;
        u.src1_reg = s1;
        u.src1_rdy = r1;
        u.src2_reg = s2;
        u.src2_rdy = r2;
        u.dst_reg  = s1 ^ s2;
        u.payload  = pl;
        return u;
    endfunction

    logic [15:0] age_exp [7];

    initial begin
        // Reset state
        repeat (3) tick();
        chk("reset_ready", 64'(dispatch_ready), 64'd1);
        chk("reset_sel_valid", 64'(sel_valid), 64'd0);
        chk("reset_sel_uop", 64'(sel_uop), 64'd0);
        rst = 1'b0;

        // Three independent uops, issued in order one edge after dispatch
        dispatch_valid = 1'b1;
        dispatch_uop = mk(6'd1, 1, 6'd2, 1, 16'hA001); tick();
        chk("indep_first_idle", 64'(sel_valid), 64'd0);
        dispatch_uop = mk(6'd1, 1, 6'd2, 1, 16'hA002); tick();
        chk("indep_a_valid", 64'(sel_valid), 64'd1);
        chk("indep_a", 64'(sel_uop.payload), 64'hA001);
        dispatch_uop = mk(6'd1, 1, 6'd2, 1, 16'hA003); tick();
        chk("indep_b", 64'(sel_uop.payload), 64'hA002);
        dispatch_valid = 1'b0; tick();
        chk("indep_c", 64'(sel_uop.payload), 64'hA003);
        tick();
        chk("indep_drain", 64'(sel_valid), 64'd0);

        // Wakeup: src1=7 not ready, woken on port 2
        dispatch_valid = 1'b1;
        dispatch_uop = mk(6'd7, 0, 6'd3, 1, 16'hB007); tick();
        dispatch_valid = 1'b0; tick();
        chk("wake_wait1", 64'(sel_valid), 64'd0);
        tick();
        chk("wake_wait2", 64'(sel_valid), 64'd0);
        wakeup_valid = 4'b0100; wakeup_tag[2] = 6'd7; tick();
        chk("wake_not_early", 64'(sel_valid), 64'd0);
        wakeup_valid = '0; tick();
        chk("wake_issue_valid", 64'(sel_valid), 64'd1);
        chk("wake_issue", 64'(sel_uop.payload), 64'hB007);
        tick();

        // Same-cycle wakeup on src2=12
        dispatch_valid = 1'b1;
        dispatch_uop = mk(6'd4, 1, 6'd12, 0, 16'hC00C);
        wakeup_valid = 4'b0001; wakeup_tag[0] = 6'd12; tick();
        chk("same_cycle_idle", 64'(sel_valid), 64'd0);
        dispatch_valid = 1'b0; wakeup_valid = '0; tick();
        chk("same_cycle_valid", 64'(sel_valid), 64'd1);
        chk("same_cycle_uop", 64'(sel_uop.payload), 64'hC00C);
        tick();

        // Full: 16 unready uops, distinct src1 tags 32..47
        dispatch_valid = 1'b1;
        for (int i = 0; i < D; i++) begin
            dispatch_uop = mk(6'(32 + i), 0, 6'd5, 1, 16'(16'hD000 + i));
            tick();
        end
        chk("full_ready_low", 64'(dispatch_ready), 64'd0);
        dispatch_uop = mk(6'd0, 1, 6'd0, 1, 16'hDBAD); tick();
        chk("full_17th_ready", 64'(dispatch_ready), 64'd0);
        tick();
        chk("full_17th_not_issued", 64'(sel_valid), 64'd0);
        dispatch_valid = 1'b0;
        wakeup_valid = 4'b0010; wakeup_tag[1] = 6'd32; tick();
        chk("full_still_full", 64'(dispatch_ready), 64'd0);
        wakeup_valid = '0; tick();
        chk("full_ready_back", 64'(dispatch_ready), 64'd1);
        chk("full_first_out", 64'(sel_uop.payload), 64'hD000);

        // Stall: hold the issued uop for 3 cycles
        wakeup_valid = 4'b0111;
        wakeup_tag[0] = 6'd33; wakeup_tag[1] = 6'd34; wakeup_tag[2] = 6'd35; tick();
        wakeup_valid = '0; tick();
        chk("stall_pre", 64'(sel_uop.payload), 64'hD001);
        sel_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_valid", 64'(sel_valid), 64'd1);
            chk("stall_hold_uop", 64'(sel_uop.payload), 64'hD001);
        end
        sel_stall = 1'b0; tick();
        chk("stall_release", 64'(sel_uop.payload), 64'hD002);
        tick();
        chk("stall_next", 64'(sel_uop.payload), 64'hD003);
        tick();
        chk("stall_drained", 64'(sel_valid), 64'd0);

        // Flush with a concurrent dispatch: 12 entries queued
        flush = 1'b1; dispatch_valid = 1'b1;
        dispatch_uop = mk(6'd0, 1, 6'd0, 1, 16'hEF00); tick();
        chk("flush_sel_valid", 64'(sel_valid), 64'd0);
        chk("flush_ready", 64'(dispatch_ready), 64'd1);
        flush = 1'b0; dispatch_valid = 1'b0; tick();
        chk("flush_dropped", 64'(sel_valid), 64'd0);
        // Count restarted at zero: exactly 16 accepts fill the queue again
        dispatch_valid = 1'b1;
        for (int i = 0; i < D; i++) begin
            dispatch_uop = mk(6'd48, 0, 6'd48, 0, 16'(16'hE100 + i));
            tick();
            if (i == D - 2) chk("flush_count_15", 64'(dispatch_ready), 64'd1);
        end
        chk("flush_count_16", 64'(dispatch_ready), 64'd0);
        dispatch_valid = 1'b0; flush = 1'b1; tick();
        flush = 1'b0; tick();

        // Select order after refilling non-contiguous slots
        dispatch_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dispatch_uop = mk((i == 1 || i == 3) ? 6'd41 : 6'd40, 0, 6'd9, 1, 16'(16'h7000 + i));
            tick();
        end
        dispatch_valid = 1'b0;
        wakeup_valid = 4'b0001; wakeup_tag[0] = 6'd41; tick();
        wakeup_valid = '0; tick();
        chk("age_hole1", 64'(sel_uop.payload), 64'h7001);
        tick();
        chk("age_hole3", 64'(sel_uop.payload), 64'h7003);
        dispatch_valid = 1'b1;
        dispatch_uop = mk(6'd40, 0, 6'd9, 1, 16'h70A1); tick();
        dispatch_uop = mk(6'd40, 0, 6'd9, 1, 16'h70A3); tick();
        dispatch_uop = mk(6'd40, 0, 6'd9, 1, 16'h70A6); tick();
        dispatch_valid = 1'b0;
        chk("age_refill_idle", 64'(sel_valid), 64'd0);
        wakeup_valid = 4'b1000; wakeup_tag[3] = 6'd40; tick();
        wakeup_valid = '0;
`ifdef IQ_AGE_SELECT_EN
        age_exp = '{16'h7000, 16'h7002, 16'h7004, 16'h7005, 16'h70A1, 16'h70A3, 16'h70A6};
`else
        age_exp = '{16'h7000, 16'h70A1, 16'h7002, 16'h70A3, 16'h7004, 16'h7005, 16'h70A6};
`endif
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("order_valid", 64'(sel_valid), 64'd1);
            chk("order_uop", 64'(sel_uop.payload), 64'(age_exp[i]));
        end
        tick();
        chk("order_drained", 64'(sel_valid), 64'd0);

        // Randomized traffic, with an asynchronous reset in the middle
        for (int c = 0; c < 4000; c++) begin
            dispatch_valid = ($urandom_range(0, 9) < 6);
            dispatch_uop = mk(6'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                              6'($urandom_range(0, 15)), ($urandom_range(0, 1) == 0),
                              16'($urandom_range(0, 65535)));
            for (int p = 0; p < W; p++) begin
                wakeup_valid[p] = ($urandom_range(0, 2) == 0);
                wakeup_tag[p]   = 6'($urandom_range(0, 15));
            end
            flush     = ($urandom_range(0, 79) == 0);
            sel_stall = ($urandom_range(0, 3) == 0);
            if (c == 2000) rst = 1'b1;
            if (c == 2003) rst = 1'b0;
            tick();
        end

        dispatch_valid = 1'b0; wakeup_valid = '0; flush = 1'b0; sel_stall = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
